// File: rtl/cpu_clock_gen_if.sv
// Control inputs and clock/strobe outputs of the CPU virtual clock generator.
interface cpu_clock_gen_if #(
    parameter int unsigned SEL_W = 4,
    parameter int unsigned CNT_W = 32
);
    logic [SEL_W-1:0] rate_sel;
    logic [1:0]       mode;
    logic             step_btn;
    logic             clock;
    logic             clk_rise;
    logic             clk_fall;
    logic [CNT_W-1:0] cycle_count;
    logic [31:0]      active_div;

    modport master (
        output rate_sel, mode, step_btn,
        input  clock, clk_rise, clk_fall, cycle_count, active_div
    );

    modport slave (
        input  rate_sel, mode, step_btn,
        output clock, clk_rise, clk_fall, cycle_count, active_div
    );
endinterface

// File: rtl/cpu_clock_gen.sv
// CPU virtual clock: table-selected divisor, run / single-step / halt modes,
// changes applied only at period boundaries, plus edge strobes and a rise counter.
module cpu_clock_gen #(
    parameter int unsigned           N_RATES         = 5,
    parameter int unsigned           SEL_W           = 4,
    parameter logic [N_RATES*32-1:0] DIV_TABLE       = {32'd128, 32'd50000, 32'd500000,
                                                        32'd5000000, 32'd50000000},
    parameter int unsigned           DEBOUNCE_CYCLES = 500000,
    parameter int unsigned           CNT_W           = 32
) (
    input  logic          physical_clock,
    input  logic          reset,
    cpu_clock_gen_if.slave cg_if
);
    localparam int unsigned DB_W = $clog2(DEBOUNCE_CYCLES) + 1;

    typedef enum logic [1:0] {HALT, HIGH, LOW, STEP_WAIT} state_t;

    function automatic logic [31:0] div_of(input logic [SEL_W-1:0] sel);
        int unsigned idx;
        logic [31:0] d;
        idx = (32'(sel) >= N_RATES) ? N_RATES - 1 : 32'(sel);
        d   = DIV_TABLE[idx*32 +: 32];
        return (d < 32'd2) ? 32'd2 : d;
    endfunction

    state_t           state_q;
    logic [31:0]      phase_q, div_q;
    logic [CNT_W-1:0] cnt_q;
    logic             clock_q, rise_q, fall_q;

    logic [1:0]       sync_q;
    logic             stable_q, arm_q, pulse_q;
    logic [DB_W-1:0]  db_cnt_q;

    logic        run_w, step_w, halt_w, start_w;
    logic [31:0] high_w, low_w;

    assign run_w  = (cg_if.mode == 2'b00);
    assign step_w = (cg_if.mode == 2'b01);
    assign halt_w = cg_if.mode[1];
    assign high_w = div_q >> 1;
    assign low_w  = div_q - high_w;

    always_comb begin
        start_w = 1'b0;
        case (state_q)
            HALT:      start_w = run_w;
            LOW:       start_w = run_w && (phase_q == low_w - 32'd1);
            STEP_WAIT: start_w = run_w || (step_w && pulse_q);
            default:   start_w = 1'b0;
        endcase
    end

    always_ff @(posedge physical_clock) begin
        if (reset) begin
            state_q <= HALT;
            phase_q <= '0;
            div_q   <= div_of('0);
            cnt_q   <= '0;
            clock_q <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
            phase_q <= phase_q + 32'd1;
            if (start_w) begin
                state_q <= HIGH;
                clock_q <= 1'b1;
                rise_q  <= 1'b1;
                cnt_q   <= cnt_q + CNT_W'(1);
                div_q   <= div_of(cg_if.rate_sel);
                phase_q <= '0;
            end else begin
                case (state_q)
                    HALT: if (step_w) state_q <= STEP_WAIT;
                    HIGH: if (phase_q == high_w - 32'd1) begin
                        state_q <= LOW;
                        clock_q <= 1'b0;
                        fall_q  <= 1'b1;
                        phase_q <= '0;
                    end
                    // Run restarts are handled by start_w; otherwise park by mode.
                    LOW: if (phase_q == low_w - 32'd1) begin
                        state_q <= step_w ? STEP_WAIT : HALT;
                        phase_q <= '0;
                    end
                    STEP_WAIT: if (halt_w) state_q <= HALT;
                    default: state_q <= HALT;
                endcase
            end
        end
    end

    // Synchroniser resets to "pressed" so a key held through reset is seen as
    // pressed; arm_q then blocks pulses until a released level is observed.
    always_ff @(posedge physical_clock) begin
        if (reset) begin
            sync_q   <= 2'b00;
            stable_q <= 1'b1;
            arm_q    <= 1'b0;
            db_cnt_q <= '0;
            pulse_q  <= 1'b0;
        end else begin
            sync_q  <= {sync_q[0], cg_if.step_btn};
            pulse_q <= 1'b0;
            if (sync_q[1] == stable_q) begin
                db_cnt_q <= '0;
                if (stable_q) arm_q <= 1'b1;
            end else if (db_cnt_q == DB_W'(DEBOUNCE_CYCLES - 1)) begin
                db_cnt_q <= '0;
                stable_q <= sync_q[1];
                pulse_q  <= arm_q && !sync_q[1];
            end else begin
                db_cnt_q <= db_cnt_q + DB_W'(1);
            end
        end
    end

    assign cg_if.clock       = clock_q;
    assign cg_if.clk_rise    = rise_q;
    assign cg_if.clk_fall    = fall_q;
    assign cg_if.cycle_count = cnt_q;
    assign cg_if.active_div  = div_q;
endmodule

// File: tb/tb_cpu_clock_gen.sv
// Bench for cpu_clock_gen: directed literal checks plus randomized stimulus
// compared every cycle against a period-position model.
module tb_cpu_clock_gen;
    localparam int unsigned N_RATES = 4;
    localparam int unsigned SEL_W   = 4;
    localparam int unsigned DB      = 4;
    localparam int unsigned CNT_W   = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    bit   chk_en = 1'b0;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    cpu_clock_gen_if #(.SEL_W(SEL_W), .CNT_W(CNT_W)) bus ();

    cpu_clock_gen #(
        .N_RATES(N_RATES), .SEL_W(SEL_W),
        .DIV_TABLE({32'd8, 32'd1, 32'd4, 32'd5}),
        .DEBOUNCE_CYCLES(DB), .CNT_W(CNT_W)
    ) dut (
        .physical_clock(clk),
        .reset(rst),
        .cg_if(bus)
    );

    int tbl [N_RATES] = '{5, 4, 1, 8};

    function automatic int clampdiv(input int sel);
        int d;
        d = (sel >= N_RATES) ? tbl[N_RATES-1] : tbl[sel];
        return (d < 2) ? 2 : d;
    endfunction

    // Model: m_pos is the position inside the current period (-1 when idle).
    int m_pos, m_D, m_cnt;
    bit m_wait, m_pulse, m_stable, m_arm;
    bit m_sq[$];
    bit m_win[$];
    bit run, stp, start, s, acc;

    always @(posedge clk) begin
        if (rst) begin
            m_pos = -1; m_wait = 0; m_cnt = 0; m_D = clampdiv(0);
            m_pulse = 0; m_stable = 1; m_arm = 0;
            m_sq = {}; m_sq.push_back(1'b0); m_sq.push_back(1'b0);
            m_win = {};
        end else begin
            run = (bus.mode == 2'b00);
            stp = (bus.mode == 2'b01);
            start = 0;
            if (m_pos < 0) begin
                start = run || (m_wait && stp && m_pulse);
                m_wait = stp;
            end else if (m_pos == m_D - 1) begin
                if (run) start = 1;
                else begin m_pos = -1; m_wait = stp; end
            end else begin
                m_pos++;
            end
            if (start) begin
                m_pos = 0;
                m_D = clampdiv(int'(bus.rate_sel));
                m_cnt = (m_cnt + 1) % (1 << CNT_W);
            end
            // Press accepted once the last DB synchronised samples all differ from the stable level.
            m_sq.push_back(bus.step_btn);
            s = m_sq.pop_front();
            m_win.push_back(s);
            if (m_win.size() > DB) void'(m_win.pop_front());
            acc = (m_win.size() == DB);
            foreach (m_win[i]) if (m_win[i] == m_stable) acc = 0;
            m_pulse = acc && !s && m_arm;
            if (acc) m_stable = s;
            else if (s && m_stable) m_arm = 1;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("m_clock", 32'(bus.clock),    32'(m_pos >= 0 && m_pos < m_D/2));
            chk("m_rise",  32'(bus.clk_rise), 32'(m_pos == 0));
            chk("m_fall",  32'(bus.clk_fall), 32'(m_pos == m_D/2));
            chk("m_count", 32'(bus.cycle_count), 32'(m_cnt));
            chk("m_div",   bus.active_div,    32'(m_D));
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        @(negedge clk);
    endtask

    int hold;

    initial begin
        bus.rate_sel = 4'd3; bus.mode = 2'b00; bus.step_btn = 1'b1;
        repeat (3) @(posedge clk);
        chk_en = 1;
        @(negedge clk);
        chk("rst_clock", 32'(bus.clock), 0);
        chk("rst_rise",  32'(bus.clk_rise), 0);
        chk("rst_fall",  32'(bus.clk_fall), 0);
        chk("rst_count", 32'(bus.cycle_count), 0);
        chk("rst_div",   bus.active_div, 5);
        rst = 1'b0;
        step(1);  chk("t1_clock", 32'(bus.clock), 1); chk("t1_rise", 32'(bus.clk_rise), 1);
                  chk("t1_count", 32'(bus.cycle_count), 1); chk("t1_div", bus.active_div, 8);
        step(4);  chk("t1_fall", 32'(bus.clk_fall), 1); chk("t1_low", 32'(bus.clock), 0);
        step(12); chk("t1_count3", 32'(bus.cycle_count), 3); chk("t1_rise3", 32'(bus.clk_rise), 1);
        bus.rate_sel = 4'd0;
        step(3);  chk("t3_keep_high", 32'(bus.clock), 1); chk("t3_keep_div", bus.active_div, 8);
        step(1);  chk("t3_fall", 32'(bus.clk_fall), 1);
        step(4);  chk("t2_rise5", 32'(bus.clk_rise), 1); chk("t2_div5", bus.active_div, 5);
                  chk("t2_count4", 32'(bus.cycle_count), 4);
        step(2);  chk("t2_fall5", 32'(bus.clk_fall), 1);
        bus.rate_sel = 4'd2;
        step(3);  chk("t2_rise2", 32'(bus.clk_rise), 1); chk("t2_div2", bus.active_div, 2);
        step(1);  chk("t2_fall2", 32'(bus.clk_fall), 1);
        step(1);  chk("t2_count6", 32'(bus.cycle_count), 6);
        bus.rate_sel = 4'd3; bus.mode = 2'b10;
        step(1);  chk("t5_fall", 32'(bus.clk_fall), 1);
        step(5);  chk("t5_halt_clock", 32'(bus.clock), 0); chk("t5_halt_count", 32'(bus.cycle_count), 6);
        bus.mode = 2'b00;
        step(1);  chk("t5_resume", 32'(bus.clock), 1); chk("t5_count7", 32'(bus.cycle_count), 7);
        bus.mode = 2'b01;
        step(10); chk("t4_parked", 32'(bus.clock), 0);
        bus.step_btn = 1'b0;
        step(2);  bus.step_btn = 1'b1;
        step(10); chk("t4_bounce", 32'(bus.cycle_count), 7); chk("t4_bounce_clk", 32'(bus.clock), 0);
        bus.step_btn = 1'b0;
        step(6);  chk("t4_pre_rise", 32'(bus.clock), 0);
        step(1);  chk("t4_rise", 32'(bus.clock), 1); chk("t6_wrap", 32'(bus.cycle_count), 0);
        step(3);  bus.step_btn = 1'b1;
        step(15); chk("t4_one_period", 32'(bus.clock), 0); chk("t4_one_count", 32'(bus.cycle_count), 0);
        bus.mode = 2'b00;
        step(1);  chk("t6_high", 32'(bus.clock), 1);
        rst = 1'b1;
        step(1);  chk("t6_rst_clock", 32'(bus.clock), 0); chk("t6_rst_count", 32'(bus.cycle_count), 0);
        rst = 1'b0;

        hold = 0;
        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(0, 39) == 0) bus.rate_sel = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 59) == 0) bus.mode = 2'($urandom_range(0, 3));
            if (hold == 0) begin
                bus.step_btn = ~bus.step_btn;
                hold = $urandom_range(1, 14);
            end else begin
                hold--;
            end
            rst = ($urandom_range(0, 499) == 0);
            step(1);
        end
        rst = 1'b0;
        step(2);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
